ets_cmp_frame_packer: RTL and testbench
=======================================

ETS_CMP_FRAME_PACKER -- requirements
Module: ets_cmp_frame_packer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'hA5A5_5AC3, header word that opens every frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, output FIFO depth in 32-bit words (power of 2, >=2).
REQ-003 SHALL have port shifting_clk  in  1  phase-shifted sampling clock; all logic on its rising edge.
REQ-004 SHALL have port free_run_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmp_data  in  1  registered comparator bit, one sample per cycle.
REQ-006 SHALL have port enable  in  1  frame start request, sampled only in IDLE.
REQ-007 SHALL have port frame_len  in  8  payload words per frame, latched at frame start; 0 treated as 1.
REQ-008 SHALL have port m_data  out  32  FIFO head word.
REQ-009 SHALL have port m_valid  out  1  FIFO not empty.
REQ-010 SHALL have port m_ready  in  1  consumer accept; word transfers when m_valid && m_ready.
REQ-011 SHALL have port m_last  out  1  head word is a trailer.
REQ-012 SHALL have port overflow  out  1  sticky drop flag.
REQ-013 SHALL have port clear_overflow  in  1  single-cycle clear of overflow.
REQ-014 SHALL have port frame_count  out  16  completed frames, wraps 0xFFFF->0x0000.
REQ-015 SHALL have port busy  out  1  FSM not in IDLE.

Function
REQ-016 SHALL implement FSM IDLE, PAYLOAD, TRAILER.
REQ-017 IDLE with enable=1: push SYNC_WORD (m_last=0), latch frame_len, clear bit_cnt, word_cnt, ones_cnt; next state PAYLOAD.
REQ-018 PAYLOAD: each cycle write cmp_data into shift word bit bit_cnt (LSB = first sample), add cmp_data to ones_cnt, bit_cnt increments mod 32.
REQ-019 PAYLOAD, bit_cnt=31: push completed word (including this cycle's sample), word_cnt++; if word_cnt+1 equals latched length, next state TRAILER.
REQ-020 TRAILER: push {frame_count+1, ones_cnt[15:0]} with m_last=1, frame_count++, next state IDLE; no cmp_data sampled this cycle.
REQ-021 enable deassertion outside IDLE SHALL be ignored; frame completes.
REQ-022 Pushed word SHALL appear at m_data/m_valid the cycle after the push edge (FIFO first-word-fall-through, 1-cycle latency).
REQ-023 FIFO full means occupancy == FIFO_DEPTH at the push edge; push while full SHALL be dropped even if a pop occurs the same cycle.
REQ-024 Simultaneous push and pop when not full SHALL keep occupancy unchanged.
REQ-025 Dropped push SHALL set overflow, abort frame (next state IDLE), not increment frame_count; words already queued remain.
REQ-026 clear_overflow SHALL clear overflow next cycle; new drop in same cycle wins (overflow stays 1).
REQ-027 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 ones_cnt SHALL be 16 bits; max payload 255*32=8160 never wraps.
REQ-029 busy SHALL be 1 in PAYLOAD and TRAILER.

Reset
REQ-030 Reset assertion SHALL immediately force: FSM IDLE, FIFO empty, m_valid=0, m_last=0, m_data=0, overflow=0, frame_count=0, busy=0, all counters 0.
REQ-031 Reset mid-frame SHALL discard partial frame and queued words; first frame after release starts only on enable in IDLE.

Verification
REQ-032 frame_len=1, cmp_data=1 constant, m_ready=1, enable pulse: -> words A5A55AC3, FFFFFFFF, 00010020 (m_last=1); frame_count=1.
REQ-033 frame_len=0, cmp_data alternating starting 1: -> payload 55555555, trailer 00010010; identical to frame_len=1.
REQ-034 FIFO_DEPTH=8, m_ready=0, frame_len=10: -> 8 words queued, 9th push dropped, overflow=1, FSM IDLE, frame_count=0; drain yields exactly 8 words, m_last never 1.
REQ-035 overflow=1, clear_overflow pulse coincident with new drop -> overflow stays 1; pulse alone -> 0 next cycle.
REQ-036 Assert free_run_rst_n=0 at bit_cnt=17 of second payload word -> all outputs at reset values same cycle; after release and enable, next frame header is A5A55AC3, frame_count restarts at 1.
REQ-037 m_ready toggled randomly, 300 frames frame_len=3: -> no overflow, frame_count wraps not reached, every 5th word has m_last=1, trailer upper 16 bits increment by 1.

Source files
------------

// File: rtl/ets_cmp_frame_packer.sv
// Packs a serial comparator bit stream into framed 32-bit words (sync header, payload, trailer)
// and queues them in a first-word-fall-through FIFO with a sticky overflow flag.
module ets_cmp_frame_packer #(
    parameter logic [31:0] SYNC_WORD  = 32'hA5A5_5AC3,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        shifting_clk,
    input  logic        free_run_rst_n,
    input  logic        cmp_data,
    input  logic        enable,
    input  logic [7:0]  frame_len,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic [15:0] frame_count,
    output logic        busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TRAILER} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_len;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_word_cnt;
    logic [15:0] r_ones_cnt;
    logic [31:0] r_shift;
    logic [15:0] r_frame_count;
    logic        r_overflow;

    logic [32:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic        w_push;
    logic [32:0] w_push_data;
    logic        w_frame_done;
    logic        w_full;
    logic        w_drop;
    logic        w_accept;
    logic        w_pop;
    logic [31:0] w_sample_word;
    logic [7:0]  w_word_cnt_inc;
    logic [32:0] w_head;

    assign w_word_cnt_inc = r_word_cnt + 8'd1;
    assign w_full         = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_drop         = w_push && w_full;
    assign w_accept       = w_push && !w_full;
    assign w_pop          = (r_count != '0) && m_ready;

    always_comb begin
        w_sample_word            = r_shift;
        w_sample_word[r_bit_cnt] = cmp_data;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_data  = '0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_push       = 1'b1;
                    w_push_data  = {1'b0, SYNC_WORD};
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (r_bit_cnt == 5'd31) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b0, w_sample_word};
                    if (w_word_cnt_inc == r_len) begin
                        w_state_next = S_TRAILER;
                    end
                end
            end
            S_TRAILER: begin
                w_push       = 1'b1;
                w_push_data  = {1'b1, r_frame_count + 16'd1, r_ones_cnt};
                w_frame_done = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        // A dropped word makes the frame unrecoverable, so abandon it.
        if (w_drop) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= 8'd0;
            r_bit_cnt     <= 5'd0;
            r_word_cnt    <= 8'd0;
            r_ones_cnt    <= 16'd0;
            r_shift       <= 32'd0;
            r_frame_count <= 16'd0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && enable) begin
                r_len      <= (frame_len == 8'd0) ? 8'd1 : frame_len;
                r_bit_cnt  <= 5'd0;
                r_word_cnt <= 8'd0;
                r_ones_cnt <= 16'd0;
            end
            if (r_state == S_PAYLOAD) begin
                r_shift    <= w_sample_word;
                r_ones_cnt <= r_ones_cnt + {15'd0, cmp_data};
                r_bit_cnt  <= r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd31) begin
                    r_word_cnt <= w_word_cnt_inc;
                end
            end
            if (w_frame_done && w_accept) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked solely by r_count.
    always_ff @(posedge shifting_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign m_valid     = (r_count != '0);
    assign m_data      = m_valid ? w_head[31:0] : 32'd0;
    assign m_last      = m_valid & w_head[32];
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ets_cmp_frame_packer.sv
// Bench for ets_cmp_frame_packer: frame-level reference model compared every cycle,
// plus literal checks on popped words for the directed scenarios.
module tb_ets_cmp_frame_packer;
    localparam int          FD   = 8;
    localparam logic [31:0] SYNC = 32'hA5A5_5AC3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmp_data = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  frame_len = 8'd0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [15:0] frame_count;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    ets_cmp_frame_packer #(.SYNC_WORD(SYNC), .FIFO_DEPTH(FD)) dut (
        .shifting_clk   (clk),
        .free_run_rst_n (rst_n),
        .cmp_data       (cmp_data),
        .enable         (enable),
        .frame_len      (frame_len),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frame_count    (frame_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: frames are a list of samples; a word leaves every 32 samples,
    // the trailer after len*32 samples; the FIFO is a bounded queue.
    logic [32:0] mq[$];
    int          mphase = 0;   // 0 waiting, 1 collecting samples, 2 trailer due
    int          mlen = 0;
    int          msamp = 0;
    int          mones = 0;
    logic [31:0] mword = '0;
    logic [15:0] mfc = '0;
    bit          mov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit          do_push;
        bit          is_trl;
        bit          was_full;
        logic [32:0] pw;
        if (!rst_n) begin
            mq.delete();
            mphase = 0; msamp = 0; mones = 0; mword = '0; mfc = '0; mov = 1'b0;
        end else begin
            do_push  = 1'b0;
            is_trl   = 1'b0;
            pw       = '0;
            was_full = (mq.size() == FD);
            if (mq.size() != 0 && m_ready) void'(mq.pop_front());
            case (mphase)
                0: if (enable) begin
                    do_push = 1'b1; pw = {1'b0, SYNC};
                    mlen = (frame_len == 8'd0) ? 1 : int'(frame_len);
                    msamp = 0; mones = 0; mword = '0; mphase = 1;
                end
                1: begin
                    mword[msamp % 32] = cmp_data;
                    mones += int'(cmp_data);
                    msamp++;
                    if (msamp % 32 == 0) begin
                        do_push = 1'b1; pw = {1'b0, mword};
                        if (msamp == mlen * 32) mphase = 2;
                    end
                end
                default: begin
                    do_push = 1'b1; is_trl = 1'b1;
                    pw = {1'b1, mfc + 16'd1, 16'(mones)};
                    mphase = 0;
                end
            endcase
            if (do_push && was_full) begin
                mphase = 0; mov = 1'b1;
            end else begin
                if (do_push) begin
                    mq.push_back(pw);
                    if (is_trl) mfc = mfc + 16'd1;
                end
                if (clear_overflow) mov = 1'b0;
            end
        end
    end

    // Popped-word log, sampled mid-cycle just before the popping edge.
    logic [32:0] plog[$];

    always @(negedge clk) begin
        check("m_valid", {32'd0, m_valid}, {32'd0, mq.size() != 0});
        if (mq.size() != 0 && m_valid) begin
            check("m_data", {1'b0, m_data}, {1'b0, mq[0][31:0]});
            check("m_last", {32'd0, m_last}, {32'd0, mq[0][32]});
        end
        check("overflow", {32'd0, overflow}, {32'd0, mov});
        check("frame_count", {17'd0, frame_count}, {17'd0, mfc});
        check("busy", {32'd0, busy}, {32'd0, mphase != 0});
        if (rst_n && m_valid && m_ready) begin
            plog.push_back({m_last, m_data});
            $display("pop %0d: data=%h last=%b", plog.size() - 1, m_data, m_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        plog.delete();
    endtask

    task automatic run_frame(input logic [7:0] len, input int mode);
        int n;
        n = (len == 8'd0) ? 32 : int'(len) * 32;
        frame_len = len;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mode == 0)      cmp_data = 1'b1;
            else if (mode == 1) cmp_data = (i % 2 == 0);
            else                cmp_data = 1'($urandom_range(0, 1));
            tick();
        end
        tick();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (mq.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        tick();
        check(name, {1'b0, 32'(mq.size())}, 33'd0);
    endtask

    task automatic check_log(input string name, input int idx, input logic [32:0] exp);
        if (idx >= plog.size()) check(name, 33'h1_DEAD_BEEF, exp);
        else                    check(name, plog[idx], exp);
    endtask

    initial begin
        int ntrl;
        bit bad_last;
        bit bad_cnt;
        // Reset values
        tick();
        check("rst_m_valid", {32'd0, m_valid}, 33'd0);
        check("rst_m_data", {1'b0, m_data}, 33'd0);
        check("rst_frame_count", {17'd0, frame_count}, 33'd0);
        check("rst_busy", {32'd0, busy}, 33'd0);
        rst_n = 1'b1;
        plog.delete();

        // Single all-ones word frame
        m_ready = 1'b1;
        run_frame(8'd1, 0);
        drain("drain_len1");
        check_log("len1_hdr", 0, {1'b0, 32'hA5A5_5AC3});
        check_log("len1_pay", 1, {1'b0, 32'hFFFF_FFFF});
        check_log("len1_trl", 2, {1'b1, 32'h0001_0020});
        check("len1_frame_count", {17'd0, frame_count}, 33'd1);

        // Reset mid-frame at bit 17 of the second payload word
        m_ready = 1'b0;
        frame_len = 8'd3;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 49; i++) begin
            cmp_data = 1'($urandom_range(0, 1));
            tick();
        end
        check("pre_rst_busy", {32'd0, busy}, 33'd1);
        check("pre_rst_valid", {32'd0, m_valid}, 33'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {32'd0, m_valid}, 33'd0);
        check("async_rst_data", {1'b0, m_data}, 33'd0);
        check("async_rst_last", {32'd0, m_last}, 33'd0);
        check("async_rst_fc", {17'd0, frame_count}, 33'd0);
        check("async_rst_busy", {32'd0, busy}, 33'd0);
        tick();
        rst_n = 1'b1;
        plog.delete();
        repeat (3) tick();
        check("post_rst_idle", {32'd0, busy}, 33'd0);
        m_ready = 1'b1;
        run_frame(8'd1, 0);
        drain("drain_after_rst");
        check_log("after_rst_hdr", 0, {1'b0, 32'hA5A5_5AC3});
        check_log("after_rst_trl", 2, {1'b1, 32'h0001_0020});
        check("after_rst_fc", {17'd0, frame_count}, 33'd1);

        // frame_len=0 behaves as 1; alternating bits
        do_reset();
        run_frame(8'd0, 1);
        drain("drain_len0");
        check_log("len0_hdr", 0, {1'b0, 32'hA5A5_5AC3});
        check_log("len0_pay", 1, {1'b0, 32'h5555_5555});
        check_log("len0_trl", 2, {1'b1, 32'h0001_0010});
        check("len0_count", {1'b0, 32'(plog.size())}, 33'd3);

        // Overflow with a stalled consumer
        do_reset();
        m_ready = 1'b0;
        run_frame(8'd10, 0);
        check("ovf_set", {32'd0, overflow}, 33'd1);
        check("ovf_idle", {32'd0, busy}, 33'd0);
        check("ovf_fc", {17'd0, frame_count}, 33'd0);
        frame_len = 8'd1;
        enable = 1'b1;
        clear_overflow = 1'b1;
        tick();
        enable = 1'b0;
        clear_overflow = 1'b0;
        check("ovf_clear_vs_drop", {32'd0, overflow}, 33'd1);
        check("ovf_abort_idle", {32'd0, busy}, 33'd0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", {32'd0, overflow}, 33'd0);
        m_ready = 1'b1;
        drain("drain_ovf");
        check("ovf_drain_count", {1'b0, 32'(plog.size())}, 33'd8);
        check_log("ovf_hdr", 0, {1'b0, 32'hA5A5_5AC3});
        for (int i = 1; i < 8; i++) check_log("ovf_pay", i, {1'b0, 32'hFFFF_FFFF});

        // Many short frames with a randomly stalling consumer
        plog.delete();
        frame_len = 8'd3;
        enable = 1'b1;
        for (int c = 0; c < 300 * 98 + 500 && mfc < 16'd300; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            cmp_data = 1'($urandom_range(0, 1));
            tick();
        end
        enable = 1'b0;
        check("stress_frames", {17'd0, mfc}, 33'd300);
        m_ready = 1'b1;
        drain("drain_stress");
        check("stress_fc", {17'd0, frame_count}, 33'd300);
        check("stress_no_ovf", {32'd0, overflow}, 33'd0);
        check("stress_words", {1'b0, 32'(plog.size())}, 33'd1500);
        ntrl = 0;
        bad_last = 1'b0;
        bad_cnt = 1'b0;
        for (int i = 0; i < plog.size(); i++) begin
            if (plog[i][32] != (i % 5 == 4)) bad_last = 1'b1;
            if (i % 5 == 4) begin
                ntrl++;
                if (plog[i][31:16] != 16'(ntrl)) bad_cnt = 1'b1;
            end
        end
        check("stress_last_pattern", {32'd0, bad_last}, 33'd0);
        check("stress_trailer_seq", {32'd0, bad_cnt}, 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
